// File: rtl/stream_mux_nto1.sv
// rtl/stream_mux_nto1.sv - registered N-to-1 stream mux, fixed-select or round-robin
// One output register stage; in_ready is combinational from grant and output space.
module stream_mux_nto1 #(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int SEL_W   = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic [COUNT_W-1:0] out_count
);

  localparam int SLOTS = 2**SEL_W;

  // Channels padded to the full sel range so out-of-range indices read as idle.
  logic [SLOTS-1:0] valid_ext;
  logic [WIDTH-1:0] ch_data [SLOTS];
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_valid;
  logic             space;
  logic             accept;

  always_comb begin
    valid_ext = '0;
    for (int i = 0; i < SLOTS; i++) ch_data[i] = '0;
    for (int i = 0; i < N; i++) begin
      valid_ext[i] = in_valid[i];
      ch_data[i]   = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan from farthest to nearest so the first valid channel after last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    rr_idx      = '0;
    if (mode) begin
      for (int k = N; k >= 1; k--) begin
        rr_idx = SEL_W'((int'(last) + k) % N);
        if (valid_ext[rr_idx]) begin
          grant_valid = 1'b1;
          grant       = rr_idx;
        end
      end
    end else begin
      grant_valid = valid_ext[sel];
      grant       = sel;
    end
  end

  assign space  = !out_valid || out_ready;
  assign accept = !rst && space && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) in_ready[i] = accept && (grant == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_count <= '0;
      last      <= SEL_W'(N - 1);
    end else begin
      if (out_valid && out_ready) out_count <= out_count + COUNT_W'(1);
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant];
        out_sel   <= grant;
        if (mode) last <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb/tb_stream_mux_nto1.sv - scoreboard bench for stream_mux_nto1 (N=4, SEL_W=3, COUNT_W=2)
module tb_stream_mux_nto1;

  localparam int WIDTH   = 32;
  localparam int N       = 4;
  localparam int SEL_W   = 3;
  localparam int COUNT_W = 2;
  localparam int SBW     = SEL_W + WIDTH;

  logic               clk;
  logic               rst;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic [COUNT_W-1:0] out_count;

  logic [WIDTH-1:0]   ch [N];
  logic [SBW-1:0]     sb [$];
  logic [COUNT_W-1:0] exp_count;
  int checks;
  int errors;

  stream_mux_nto1 #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = ch[i];
  end

  // Every completed output handshake pops and checks one expected beat.
  always @(negedge clk) begin
    logic [SBW-1:0] exp_beat;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got sel=%0d data=%h, none expected", out_sel, out_data);
      end else begin
        exp_beat = sb.pop_front();
        if ({out_sel, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL beat got sel=%0d data=%h expected sel=%0d data=%h",
                   out_sel, out_data, exp_beat[SBW-1:WIDTH], exp_beat[WIDTH-1:0]);
        end
      end
      exp_count = exp_count + COUNT_W'(1);
    end
  end

  task automatic push(input int s, input logic [WIDTH-1:0] d);
    sb.push_back({SEL_W'(s), d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || out_valid !== 1'b0) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d out_valid=%b expected 0 and 0", name, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) ch[i] = 32'hDEAD0000 + i;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    if (out_count !== '0) begin errors++; $display("FAIL reset_out_count got %0d expected 0", out_count); end
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b expected 0000", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0;
    exp_count = '0;
    tick();
  endtask

  task automatic test_fixed;
    mode = 1'b0; sel = 3'd0; out_ready = 1'b1; in_valid = '1;
    ch[0] = 32'hAAAAAAAA; ch[1] = 32'h55AAAAAA; ch[2] = $urandom; ch[3] = $urandom;
    for (int i = 0; i < 3; i++) begin
      push(0, 32'hAAAAAAAA);
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_sel0_rate got out_valid=%b expected 1", out_valid); end
    end
    sel = 3'd1;
    for (int i = 0; i < 3; i++) begin
      push(1, 32'h55AAAAAA);
      tick();
      checks++;
      if (out_sel !== 3'd1 || out_data !== 32'h55AAAAAA) begin
        errors++;
        $display("FAIL fixed_sel1 got sel=%0d data=%h expected 1 55aaaaaa", out_sel, out_data);
      end
    end
    in_valid = '0;
    wait_drain("fixed");
  endtask

  task automatic test_round_robin;
    mode = 1'b1; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) ch[i] = WIDTH'(i);
    for (int k = 0; k < 5; k++) begin
      push(k % N, WIDTH'(k % N));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== SEL_W'(k % N)) begin
        errors++;
        $display("FAIL rr_seq step %0d got valid=%b sel=%0d expected 1 %0d", k, out_valid, out_sel, k % N);
      end
    end
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      push(2, 32'd2);
      tick();
    end
    in_valid = '0;
    wait_drain("rr");
  endtask

  task automatic test_backpressure;
    mode = 1'b0; sel = 3'd0; out_ready = 1'b0;
    ch[0] = 32'h11; in_valid = 4'b0001;
    push(0, 32'h11);
    tick();
    ch[0] = 32'h22;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h11 || in_ready !== 4'b0000 || out_count !== exp_count) begin
        errors++;
        $display("FAIL stall cycle %0d got valid=%b data=%h in_ready=%b count=%0d expected 1 11 0000 %0d",
                 k, out_valid, out_data, in_ready, out_count, exp_count);
      end
    end
    out_ready = 1'b1;
    push(0, 32'h22);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h22) begin
      errors++;
      $display("FAIL stall_release got valid=%b data=%h expected 1 22", out_valid, out_data);
    end
    in_valid = '0;
    wait_drain("backpressure");
  endtask

  task automatic test_bad_sel;
    mode = 1'b0; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) ch[i] = 32'hB0 + i;
    sel = 3'd1;
    push(1, 32'hB1);
    tick();
    sel = 3'd5;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bad_sel5 got valid=%b in_ready=%b expected 0 0000", out_valid, in_ready);
    end
    sel = 3'd4;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_sel !== 3'd1 || out_data !== 32'hB1) begin
      errors++;
      $display("FAIL bad_sel4 got valid=%b in_ready=%b sel=%0d data=%h expected 0 0000 1 b1",
               out_valid, in_ready, out_sel, out_data);
    end
    in_valid = '0;
    wait_drain("bad_sel");
  endtask

  task automatic test_count_wrap;
    logic [COUNT_W-1:0] exp_list [5];
    exp_list[0] = 2'd1; exp_list[1] = 2'd2; exp_list[2] = 2'd3; exp_list[3] = 2'd0; exp_list[4] = 2'd1;
    rst = 1'b1;
    tick();
    sb.delete();
    exp_count = '0;
    rst = 1'b0; mode = 1'b1; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) ch[i] = 32'hC0 + i;
    for (int k = 0; k < 6; k++) push(k % N, 32'hC0 + (k % N));
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 2) begin
        checks++;
        if (out_count !== exp_list[k-2]) begin
          errors++;
          $display("FAIL count_wrap step %0d got %0d expected %0d", k - 1, out_count, exp_list[k-2]);
        end
      end
    end
    out_ready = 1'b0; in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_count !== 2'd1) begin
      errors++;
      $display("FAIL count_stall got valid=%b count=%0d expected 1 1", out_valid, out_count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_stall got valid=%b count=%0d expected 0 0", out_valid, out_count);
    end
    sb.delete();
    exp_count = '0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = '0;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) ch[i] = '0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_bad_sel();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
